// File: rtl/lamp_pkg.sv
// Shared lamp definitions: legal light codes, decoded phase values and monitor states.
// Also used by the lamp generator so both sides agree on encodings.
package lamp_pkg;

   localparam logic [2:0] LIGHT_RED    = 3'b100;
   localparam logic [2:0] LIGHT_GREEN  = 3'b010;
   localparam logic [2:0] LIGHT_YELLOW = 3'b001;

   typedef enum logic [1:0] {
      PH_GREEN  = 2'd0,
      PH_YELLOW = 2'd1,
      PH_RED    = 2'd2,
      PH_NONE   = 2'd3
   } phase_e;

   typedef enum logic {
      UNSYNC = 1'b0,
      TRACK  = 1'b1
   } state_e;

   // The only forward step allowed from each colour; PH_NONE has no successor.
   function automatic phase_e successor(input phase_e p);
      case (p)
         PH_GREEN:  successor = PH_YELLOW;
         PH_YELLOW: successor = PH_RED;
         PH_RED:    successor = PH_GREEN;
         default:   successor = PH_NONE;
      endcase
   endfunction

endpackage

// File: rtl/lamp_code_decode.sv
// Combinational decode of the 3-bit one-hot lamp code into a phase value
// and a legal flag; anything that is not exactly one known colour is illegal.
module lamp_code_decode
   import lamp_pkg::*;
(
   input  logic [2:0] light,
   output phase_e     phase,
   output logic       legal
);

   always_comb begin
      // NOTE: every output gets a default before the case so no latch is inferred.
      phase = PH_NONE;
      legal = 1'b0;
      case (light)
         LIGHT_GREEN:  begin phase = PH_GREEN;  legal = 1'b1; end
         LIGHT_YELLOW: begin phase = PH_YELLOW; legal = 1'b1; end
         LIGHT_RED:    begin phase = PH_RED;    legal = 1'b1; end
         default:      ;
      endcase
   end

endmodule

// File: rtl/lamp_monitor.sv
// Traffic-lamp sequence monitor: locks onto the colour stream, flags illegal codes,
// bad transitions and over-long dwell with sticky errors, and counts RED->GREEN rounds.
module lamp_monitor
   import lamp_pkg::*;
#(
   parameter int MAX_DWELL = 1,
   parameter int CNT_W     = 8
)(
   input  logic             clock,
   input  logic             rst_n,
   input  logic [2:0]       light,
   input  logic             err_clr,
   output logic [1:0]       phase,
   output logic             in_sync,
   output logic             code_err,
   output logic             seq_err,
   output logic             dwell_err,
   output logic [CNT_W-1:0] round_cnt
);

   localparam int              DW_W        = $clog2(MAX_DWELL + 1);
   localparam logic [DW_W-1:0] DWELL_LIMIT = DW_W'(MAX_DWELL);

   state_e           state_q, state_d;
   phase_e           last_q, last_d;
   phase_e           phase_q;
   phase_e           dec_phase;
   logic             dec_legal;
   logic [DW_W-1:0]  dwell_q, dwell_d;
   logic [CNT_W-1:0] round_q, round_d;
   logic             code_q, seq_q, dwell_err_q;
   logic             code_ev, seq_ev, dwell_ev;

   lamp_code_decode u_decode (
      .light (light),
      .phase (dec_phase),
      .legal (dec_legal)
   );

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      dwell_d  = dwell_q;
      round_d  = round_q;
      code_ev  = 1'b0;
      seq_ev   = 1'b0;
      dwell_ev = 1'b0;
      if (state_q == UNSYNC) begin
         // Illegal codes are ignored while unlocked; a legal one only resyncs.
         if (dec_legal) begin
            state_d = TRACK;
            last_d  = dec_phase;
            dwell_d = DW_W'(1);
         end
      end else if (!dec_legal) begin
         code_ev = 1'b1;
         state_d = UNSYNC;
         dwell_d = '0;
      end else if (dec_phase == successor(last_q)) begin
         last_d  = dec_phase;
         dwell_d = DW_W'(1);
         if (last_q == PH_RED) round_d = round_q + CNT_W'(1);
      end else if (dec_phase == last_q) begin
         if (dwell_q < DWELL_LIMIT) begin
            dwell_d = dwell_q + DW_W'(1);
         end else begin
            dwell_ev = 1'b1;
            state_d  = UNSYNC;
            dwell_d  = '0;
         end
      end else begin
         seq_ev  = 1'b1;
         state_d = UNSYNC;
         dwell_d = '0;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= UNSYNC;
         last_q      <= PH_RED;
         dwell_q     <= '0;
         phase_q     <= PH_NONE;
         round_q     <= '0;
         code_q      <= 1'b0;
         seq_q       <= 1'b0;
         dwell_err_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         state_q     <= state_d;
         last_q      <= last_d;
         dwell_q     <= dwell_d;
         phase_q     <= dec_phase;
         round_q     <= round_d;
         // A new error event wins over a coincident clear.
         code_q      <= code_ev  | (code_q      & ~err_clr);
         seq_q       <= seq_ev   | (seq_q       & ~err_clr);
         dwell_err_q <= dwell_ev | (dwell_err_q & ~err_clr);
      end
   end

   assign phase     = phase_q;
   assign in_sync   = (state_q == TRACK);
   assign code_err  = code_q;
   assign seq_err   = seq_q;
   assign dwell_err = dwell_err_q;
   assign round_cnt = round_q;

endmodule
